// File: rtl/qspi_rx_pkg.sv
// Shared constants and types for the dual-data QSPI receiver.
// Build macro QSPI_RX_FIFO_EN selects multi-entry receive storage (see qspi_dual_rx).
package qspi_rx_pkg;

    localparam int unsigned BITS_PER_EDGE  = 2;
    localparam int unsigned EDGES_PER_BYTE = 4;
    localparam int unsigned BYTE_W         = BITS_PER_EDGE * EDGES_PER_BYTE;
    localparam int unsigned CNT_W          = $clog2(EDGES_PER_BYTE);
    localparam int unsigned SHIFT_W        = BYTE_W - BITS_PER_EDGE;

    typedef logic [BYTE_W-1:0] rx_byte_t;

    typedef struct packed {
        logic     first;
        rx_byte_t data;
    } rx_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } rx_state_e;

endpackage

// File: rtl/qspi_rx_fifo.sv
// Receive storage with push/pop and full/empty flags; DEPTH==1 builds a single holding register.
// A full store accepts a push only when a pop happens in the same cycle.
module qspi_rx_fifo
    import qspi_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  rx_entry_t din_i,
    input  logic      pop_i,
    output rx_entry_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    generate
        if (DEPTH == 1) begin : g_hold
            logic      full_q;
            rx_entry_t data_q;
            logic      wr_c;

            assign wr_c = push_i & (~full_q | pop_i);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    if (wr_c) begin
                        data_q <= din_i;
                        full_q <= 1'b1;
                    end else if (pop_i) begin
                        full_q <= 1'b0;
                    end
                end
            end

            assign dout_o  = data_q;
            assign full_o  = full_q;
            assign empty_o = ~full_q;
        end else begin : g_ring
            localparam int unsigned PW = $clog2(DEPTH);
            localparam int unsigned CW = $clog2(DEPTH + 1);

            rx_entry_t         mem_q [DEPTH];
            logic [PW-1:0]     wptr_q;
            logic [PW-1:0]     rptr_q;
            logic [CW-1:0]     count_q;
            logic              full_c;
            logic              empty_c;
            logic              do_push_c;
            logic              do_pop_c;

            assign full_c    = (count_q == CW'(DEPTH));
            assign empty_c   = (count_q == '0);
            assign do_pop_c  = pop_i & ~empty_c;
            assign do_push_c = push_i & (~full_c | do_pop_c);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        mem_q[i] <= '0;
                    end
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    count_q <= '0;
                end else begin
                    if (do_push_c) begin
                        mem_q[wptr_q] <= din_i;
                        wptr_q        <= wptr_q + PW'(1);
                    end
                    if (do_pop_c) begin
                        rptr_q <= rptr_q + PW'(1);
                    end
                    case ({do_push_c, do_pop_c})
                        2'b10:   count_q <= count_q + CW'(1);
                        2'b01:   count_q <= count_q - CW'(1);
                        default: count_q <= count_q;
                    endcase
                end
            end

            assign dout_o  = mem_q[rptr_q];
            assign full_o  = full_c;
            assign empty_o = empty_c;
        end
    endgenerate

endmodule

// File: rtl/qspi_dual_rx.sv
// Dual-data QSPI receiver: synchronises raw pins, assembles bytes MSB-first, queues {first, byte}.
// Macro QSPI_RX_FIFO_EN: defined -> FIFO_DEPTH-entry FIFO; undefined -> single holding register.
module qspi_dual_rx
    import qspi_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] io_qd_read,
    input  logic       io_ss,
    input  logic       io_sclk,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       overrun,
    output logic       frame_active
);

`ifdef QSPI_RX_FIFO_EN
    localparam int unsigned STORE_DEPTH = FIFO_DEPTH;
`else
    // Single holding register; evaluates to 1 for any legal FIFO_DEPTH.
    localparam int unsigned STORE_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

    logic [SYNC_STAGES-1:0]                    sclk_sync_q;
    logic [SYNC_STAGES-1:0]                    ss_sync_q;
    logic [SYNC_STAGES-1:0][BITS_PER_EDGE-1:0] qd_sync_q;

    // Identical-depth synchronisers keep sclk, ss and qd mutually aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            qd_sync_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], io_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], io_ss};
            qd_sync_q   <= {qd_sync_q[SYNC_STAGES-2:0], io_qd_read};
        end
    end

    logic                     sclk_prev_q;
    logic                     rise_q;
    logic                     ss_r_q;
    logic [BITS_PER_EDGE-1:0] qd_r_q;

    // Registered edge detect; ss and qd take the same extra stage to stay aligned with rise_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            ss_r_q      <= 1'b1;
            qd_r_q      <= '0;
        end else begin
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            ss_r_q      <= ss_sync_q[SYNC_STAGES-1];
            qd_r_q      <= qd_sync_q[SYNC_STAGES-1];
        end
    end

    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               first_q;
    logic               overrun_q;
    logic               frame_active_q;

    logic      push_c;
    logic      pop_c;
    logic      full_c;
    logic      empty_c;
    rx_entry_t push_entry_c;
    rx_entry_t head_c;

    assign push_c = (state_q == ST_ACTIVE) & ~ss_r_q & rise_q
                  & (cnt_q == CNT_W'(EDGES_PER_BYTE - 1));
    assign pop_c  = rx_ready & ~empty_c;

    assign push_entry_c.first = first_q;
    assign push_entry_c.data  = {shift_q, qd_r_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            first_q        <= 1'b0;
            overrun_q      <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ss_r_q) begin
                        state_q        <= ST_ACTIVE;
                        cnt_q          <= '0;
                        first_q        <= 1'b1;
                        overrun_q      <= 1'b0;
                        frame_active_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_r_q) begin
                        // Any partial byte is abandoned; the counter restarts next frame.
                        state_q        <= ST_IDLE;
                        cnt_q          <= '0;
                        frame_active_q <= 1'b0;
                    end else if (rise_q) begin
                        shift_q <= {shift_q[SHIFT_W-BITS_PER_EDGE-1:0], qd_r_q};
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (push_c) begin
                            first_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (push_c && full_c && !pop_c) begin
                overrun_q <= 1'b1;
            end
        end
    end

    qspi_rx_fifo #(
        .DEPTH (STORE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .din_i   (push_entry_c),
        .pop_i   (pop_c),
        .dout_o  (head_c),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    assign rx_data      = head_c.data;
    assign rx_first     = head_c.first;
    assign rx_valid     = ~empty_c;
    assign overrun      = overrun_q;
    assign frame_active = frame_active_q;

endmodule

// File: doc/qspi_dual_rx.md
QSPI_DUAL_RX -- requirements
Module: qspi_dual_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of the pin synchronisers (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic in this domain.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port io_qd_read, input, 2, raw dual-data pin samples, asynchronous to clk.
REQ-006 SHALL have port io_ss, input, 1, raw active-low chip select, asynchronous.
REQ-007 SHALL have port io_sclk, input, 1, raw serial clock, asynchronous.
REQ-008 SHALL have port rx_data, output, 8, received byte at the FIFO head.
REQ-009 SHALL have port rx_valid, output, 1, rx_data is valid.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-011 SHALL have port rx_first, output, 1, head byte is the first byte of its frame.
REQ-012 SHALL have port overrun, output, 1, sticky flag: a byte was dropped.
REQ-013 SHALL have port frame_active, output, 1, synchronised select is asserted (low).

Function
REQ-014 SHALL pass io_sclk, io_ss and io_qd_read through identical SYNC_STAGES-deep synchronisers, so the three inputs stay mutually aligned.
REQ-015 SHALL detect a rising sclk edge as synced=1 with the previous synced value=0, registered one cycle later.
REQ-016 SHALL use two states. IDLE: synced ss high. ACTIVE: synced ss low. Transitions occur on the synchronised ss edge.
REQ-017 SHALL, on an IDLE->ACTIVE transition, clear the 2-bit edge counter and arm the first-byte marker.
REQ-018 SHALL, on each rising sclk edge in ACTIVE, shift in qd, MSB-first, with qd[1] as the more significant bit of each pair.
REQ-019 SHALL complete a byte on the 4th edge, counting 0..3 and wrapping to 0, and SHALL push {first, byte} into the FIFO in that cycle.
REQ-020 SHALL clear the first-byte marker after the first push of the frame.
REQ-021 SHALL, on an ACTIVE->IDLE transition with a partial byte (counter non-zero), discard the partial bits without pushing.
REQ-022 SHALL ignore sclk edges while in IDLE.
REQ-023 SHALL assert rx_valid in the cycle after the push, giving pin-to-valid latency of SYNC_STAGES+2 clk cycles.
REQ-024 SHALL pop the FIFO head when rx_valid and rx_ready are both high; rx_data and rx_first SHALL hold stable while rx_valid is high and rx_ready is low.
REQ-025 SHALL, on a push into a full FIFO with no pop in the same cycle, drop the byte and set overrun.
REQ-026 SHALL, when the FIFO is full and a push and pop occur in the same cycle, accept both; no overrun.
REQ-027 SHALL clear overrun only on reset or on an IDLE->ACTIVE transition.
REQ-028 SHALL support io_sclk frequencies up to clk/4 only; behaviour above that is unspecified.

Reset
REQ-029 SHALL, while reset is high, force rx_valid=0, rx_data=0, rx_first=0, overrun=0 and frame_active=0, set the state to IDLE, empty the FIFO, clear the counter, and set all synchronisers to ss=1, sclk=0, qd=0.
REQ-030 SHALL discard a frame that is mid-byte when reset asserts; reception SHALL restart only on a fresh ss falling edge after reset deasserts.

Configuration
REQ-031 SHALL honour macro QSPI_RX_FIFO_EN. When defined, the FIFO is FIFO_DEPTH entries deep. When undefined, storage is a single holding register: push when full and not popped sets overrun, and FIFO_DEPTH is ignored.

Structure
REQ-032 SHALL place the shared constants and types in package qspi_rx_pkg: BITS_PER_EDGE=2, EDGES_PER_BYTE=4, type rx_byte_t (8 bits), and type rx_entry_t {first, byte}.
REQ-033 SHALL implement storage in sub-module qspi_rx_fifo, with a push/pop interface carrying full and empty flags.

Verification
REQ-034 SHALL cover: ss low, 4 sclk edges with qd=2,1,3,0 -> one byte 0x9C, rx_first=1, rx_valid exactly SYNC_STAGES+2 cycles after the 4th pin edge.
REQ-035 SHALL cover: a 3-byte frame 0xA5, 0x00, 0xFF with rx_ready=1 -> three bytes in order, rx_first=1,0,0, overrun=0.
REQ-036 SHALL cover: rx_ready=0 with 5 bytes sent (FIFO enabled, depth 4) -> 4 bytes held and overrun=1; after draining and a new ss fall, overrun=0.
REQ-037 SHALL cover: ss rising after 2 edges, then a new frame with byte 0x3C -> only 0x3C delivered, with rx_first=1.
REQ-038 SHALL cover: reset asserted mid-byte then released, followed by a full frame byte 0x81 -> outputs at reset values during reset, then only 0x81 delivered.
REQ-039 SHALL cover: FIFO full, with a pop and a 4th-edge push in the same cycle -> both occur, overrun stays 0.
